// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared op codes, IO decode default and FSM encodings for mem_arbiter
package mem_arbiter_pkg;

  localparam logic [31:0] IO_BASE_DEF  = 32'h0003_0000;
  localparam int          IF_BYTES_DEF = 4;

  localparam logic [6:0] OP_LB  = 7'd1;
  localparam logic [6:0] OP_LH  = 7'd2;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_LBU = 7'd4;
  localparam logic [6:0] OP_LHU = 7'd5;
  localparam logic [6:0] OP_SB  = 7'd6;
  localparam logic [6:0] OP_SH  = 7'd7;
  localparam logic [6:0] OP_SW  = 7'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFETCH = 1'b0,
    OWN_LSB    = 1'b1
  } owner_t;

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] op_last_idx(input logic [6:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// rtl/mem_arbiter_load_extend.sv - sign/zero extension of assembled load bytes
module mem_arbiter_load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] res
);

  always_comb begin
    res = raw;
    case (op)
      OP_LB:   res = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   res = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  res = {24'd0, raw[7:0]};
      OP_LHU:  res = {16'd0, raw[15:0]};
      default: res = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide RAM/IO port arbiter between instruction fetch and load-store buffer
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
  parameter int          IF_BYTES = IF_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        ls_enable,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_data,
  input  logic        ls_is_load,
  input  logic [6:0]  ls_op,
  output logic        ls_valid,
  output logic [31:0] ls_res,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state;
  owner_t      owner;
  owner_t      last_owner;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] buf_q;
  logic [6:0]  op_q;
  logic        load_q;
  logic [1:0]  cnt;
  logic [1:0]  last_q;

  logic [31:0] cur_addr;
  logic [31:0] next_buf;
  logic [31:0] ext_res;
  logic [7:0]  wr_byte;
  logic        is_write;
  logic        io_stall;
  logic        grant_ls;

  assign cur_addr = addr_q + {30'd0, cnt};
  assign is_write = (state == ST_BUSY) && (owner == OWN_LSB) && !load_q;
  assign io_stall = is_write && ((cur_addr & IO_BASE) == IO_BASE) && io_buffer_full;
  // Round robin only matters when both request; a lone requester always wins.
  assign grant_ls = ls_enable && (!if_req || (last_owner == OWN_IFETCH));

  always_comb begin
    wr_byte  = data_q[7:0];
    next_buf = buf_q;
    case (cnt)
      2'd0: begin wr_byte = data_q[7:0];   next_buf[7:0]   = mem_din; end
      2'd1: begin wr_byte = data_q[15:8];  next_buf[15:8]  = mem_din; end
      2'd2: begin wr_byte = data_q[23:16]; next_buf[23:16] = mem_din; end
      default: begin wr_byte = data_q[31:24]; next_buf[31:24] = mem_din; end
    endcase
  end

  assign mem_wr   = rdy && is_write && !io_stall;
  assign mem_a    = (state == ST_BUSY) ? cur_addr : 32'd0;
  assign mem_dout = is_write ? wr_byte : 8'd0;

  mem_arbiter_load_extend u_load_extend (
    .op  (op_q),
    .raw (next_buf),
    .res (ext_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IFETCH;
      last_owner <= OWN_IFETCH;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      buf_q      <= 32'd0;
      op_q       <= 7'd0;
      load_q     <= 1'b0;
      cnt        <= 2'd0;
      last_q     <= 2'd0;
      if_valid   <= 1'b0;
      if_data    <= 32'd0;
      ls_valid   <= 1'b0;
      ls_res     <= 32'd0;
    end else if (rdy) begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!flush && (if_req || ls_enable)) begin
            state <= ST_BUSY;
            cnt   <= 2'd0;
            buf_q <= 32'd0;
            if (grant_ls) begin
              owner      <= OWN_LSB;
              last_owner <= OWN_LSB;
              addr_q     <= ls_addr;
              data_q     <= ls_data;
              op_q       <= ls_op;
              load_q     <= ls_is_load;
              last_q     <= op_last_idx(ls_op);
            end else begin
              owner      <= OWN_IFETCH;
              last_owner <= OWN_IFETCH;
              addr_q     <= if_addr;
              data_q     <= 32'd0;
              op_q       <= OP_LW;
              load_q     <= 1'b1;
              last_q     <= 2'(IF_BYTES - 1);
            end
          end
        end
        ST_BUSY: begin
          // Committed stores are never aborted; fetches and loads are.
          if (flush && !is_write) begin
            state <= ST_IDLE;
          end else if (!io_stall) begin
            buf_q <= next_buf;
            if (cnt == last_q) begin
              state <= ST_DONE;
              if (owner == OWN_LSB) begin
                ls_valid <= 1'b1;
                ls_res   <= load_q ? ext_res : 32'd0;
              end else begin
                if_valid <= 1'b1;
                if_data  <= next_buf;
              end
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a byte-RAM reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req, ls_enable, ls_is_load, io_buffer_full;
  logic [31:0] if_addr, ls_addr, ls_data;
  logic [6:0]  ls_op;
  logic [7:0]  mem_din;
  logic        if_valid, ls_valid, mem_wr;
  logic [31:0] if_data, ls_res, mem_a;
  logic [7:0]  mem_dout;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];
  bit          model_last_ls;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .ls_enable(ls_enable), .ls_addr(ls_addr), .ls_data(ls_data), .ls_is_load(ls_is_load),
    .ls_op(ls_op), .ls_valid(ls_valid), .ls_res(ls_res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  // The RAM presents the addressed byte mid-cycle and commits writes on the clock.
  always @(negedge clk) mem_din = ram_rd(mem_a);

  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      ram[mem_a] = mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  function automatic int n_bytes(input logic [6:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit op_is_load(input logic [6:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction

  function automatic logic [31:0] exp_load(input logic [6:0] op, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n_bytes(op); i++) v = v + (32'(ram_rd(a + 32'(i))) << (8 * i));
    if (op == OP_LB && v >= 32'd128)   v = v - 32'd256;
    if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ls(input logic [6:0] op, input logic [31:0] a, input logic [31:0] d,
                        input bit rand_rdy);
    int          n, edges;
    bit          got, ld;
    logic [31:0] expv;
    n    = n_bytes(op);
    ld   = op_is_load(op);
    expv = ld ? exp_load(op, a) : 32'd0;
    wlog_a.delete();
    wlog_d.delete();
    ls_op = op; ls_addr = a; ls_data = d; ls_is_load = ld; ls_enable = 1'b1;
    edges = 0;
    got   = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (rdy) edges++;
      else chk("frozen_mem_wr", 32'(mem_wr), 32'd0);
      got = ls_valid;
    end
    ls_enable = 1'b0;
    rdy = 1'b1;
    chk("ls_valid_seen", 32'(got), 32'd1);
    chk("ls_latency", 32'(edges), 32'(n + 1));
    chk("ls_res", ls_res, expv);
    if (ld) begin
      chk("load_no_write", 32'(wlog_a.size()), 32'd0);
    end else begin
      chk("store_nbytes", 32'(wlog_a.size()), 32'(n));
      for (int i = 0; i < n && i < wlog_a.size(); i++) begin
        chk("store_addr", wlog_a[i], a + 32'(i));
        chk("store_byte", 32'(wlog_d[i]), (d >> (8 * i)) & 32'hFF);
      end
    end
    model_last_ls = 1'b1;
    tick();
  endtask

  task automatic run_if(input logic [31:0] a);
    int          edges;
    bit          got;
    logic [31:0] expv;
    expv = exp_load(OP_LW, a);
    if_addr = a;
    if_req  = 1'b1;
    edges = 0;
    got   = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      edges++;
      got = if_valid;
    end
    if_req = 1'b0;
    chk("if_valid_seen", 32'(got), 32'd1);
    chk("if_latency", 32'(edges), 32'd5);
    chk("if_data", if_data, expv);
    model_last_ls = 1'b0;
    tick();
  endtask

  // Both requesters held; the model replays round robin from the last known owner.
  task automatic rr_test(input int n_ls, input int n_if);
    int          pls, pif;
    bit          last;
    int          exp_order [$];
    int          got_order [$];
    logic [31:0] exp_lw, exp_if;
    pls = n_ls; pif = n_if; last = model_last_ls;
    while (pls > 0 || pif > 0) begin
      if (pls > 0 && (pif == 0 || !last)) begin exp_order.push_back(1); pls--; last = 1'b1; end
      else begin exp_order.push_back(0); pif--; last = 1'b0; end
    end
    exp_lw = exp_load(OP_LW, 32'h100);
    exp_if = exp_load(OP_LW, 32'h400);
    ls_op = OP_LW; ls_addr = 32'h100; ls_is_load = 1'b1; ls_data = 32'd0;
    if_addr = 32'h400;
    pls = n_ls; pif = n_if;
    ls_enable = (pls > 0);
    if_req    = (pif > 0);
    for (int c = 0; c < 200 && (pls > 0 || pif > 0); c++) begin
      tick();
      if (ls_valid) begin
        got_order.push_back(1);
        chk("rr_ls_data", ls_res, exp_lw);
        pls--;
        if (pls == 0) ls_enable = 1'b0;
      end
      if (if_valid) begin
        got_order.push_back(0);
        chk("rr_if_data", if_data, exp_if);
        pif--;
        if (pif == 0) if_req = 1'b0;
      end
    end
    ls_enable = 1'b0;
    if_req = 1'b0;
    chk("rr_count", 32'(got_order.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < got_order.size(); i++)
      chk("rr_owner", 32'(got_order[i]), 32'(exp_order[i]));
    model_last_ls = last;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit got;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; ls_enable = 1'b0;
    ls_is_load = 1'b0; io_buffer_full = 1'b0; if_addr = 32'd0; ls_addr = 32'd0;
    ls_data = 32'd0; ls_op = 7'd0;
    model_last_ls = 1'b0;
    repeat (3) tick();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_valid", 32'(ls_valid), 32'd0);
    chk("rst_ls_res", ls_res, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    rst = 1'b0;
    tick();

    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h400] = 8'h11; ram[32'h401] = 8'h22; ram[32'h402] = 8'h33; ram[32'h403] = 8'h44;
    ram[32'h200] = 8'h80; ram[32'h202] = 8'hFF; ram[32'h203] = 8'h7F;

    rr_test(2, 1);
    run_ls(OP_LW, 32'h100, 32'd0, 1'b0);
    chk("lw_0x100", ls_res, 32'h1234_5678);
    run_ls(OP_LB, 32'h200, 32'd0, 1'b0);
    chk("lb_0x200", ls_res, 32'hFFFF_FF80);
    run_ls(OP_LBU, 32'h200, 32'd0, 1'b0);
    chk("lbu_0x200", ls_res, 32'h0000_0080);
    run_ls(OP_LH, 32'h202, 32'd0, 1'b0);
    chk("lh_0x202", ls_res, 32'h0000_7FFF);
    run_ls(OP_SH, 32'h300, 32'h0000_ABCD, 1'b0);
    run_if(32'h100);

    // IO store held off by a full UART buffer.
    wlog_a.delete(); wlog_d.delete();
    ls_op = OP_SB; ls_addr = 32'h3_0000; ls_data = 32'h0000_005A; ls_is_load = 1'b0;
    io_buffer_full = 1'b1;
    ls_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("io_stall_wr", 32'(mem_wr), 32'd0);
      chk("io_stall_valid", 32'(ls_valid), 32'd0);
    end
    io_buffer_full = 1'b0;
    #1;
    chk("io_release_wr", 32'(mem_wr), 32'd1);
    chk("io_release_a", mem_a, 32'h3_0000);
    @(posedge clk); #1;
    chk("io_valid", 32'(ls_valid), 32'd1);
    ls_enable = 1'b0;
    chk("io_nwrites", 32'(wlog_a.size()), 32'd1);
    if (wlog_a.size() > 0) chk("io_write_byte", 32'(wlog_d[0]), 32'h5A);
    model_last_ls = 1'b1;
    tick();

    // Flush aborts an in-flight fetch.
    if_addr = 32'h100; if_req = 1'b1;
    tick(); chk("flush_if_a0", mem_a, 32'h100);
    tick(); chk("flush_if_a1", mem_a, 32'h101);
    tick(); chk("flush_if_a2", mem_a, 32'h102);
    flush = 1'b1; if_req = 1'b0;
    tick();
    flush = 1'b0;
    chk("flush_if_idle_a", mem_a, 32'd0);
    got = if_valid;
    for (int i = 0; i < 6; i++) begin tick(); got = got | if_valid; end
    chk("flush_if_no_valid", 32'(got), 32'd0);
    model_last_ls = 1'b0;

    // Flush cannot abort a committed store.
    wlog_a.delete(); wlog_d.delete();
    ls_op = OP_SW; ls_addr = 32'h500; ls_data = 32'hDEAD_BEEF; ls_is_load = 1'b0;
    ls_enable = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin tick(); got = ls_valid; end
    ls_enable = 1'b0;
    chk("flush_sw_valid", 32'(got), 32'd1);
    chk("flush_sw_nbytes", 32'(wlog_a.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++)
      chk("flush_sw_byte", {wlog_a[i][23:0], wlog_d[i]},
          {24'h000500 + 24'(i), 8'((32'hDEAD_BEEF >> (8 * i)) & 32'hFF)});
    model_last_ls = 1'b1;
    tick();

    // Randomized traffic with rdy stalls.
    for (int i = 0; i < 256; i++) ram[32'h1000 + 32'(i)] = 8'($urandom);
    for (int it = 0; it < 30; it++) begin
      int          sel;
      logic [31:0] a;
      sel = $urandom_range(0, 8);
      a   = 32'h1000 + 32'($urandom_range(0, 250));
      if (sel == 8) run_if(a);
      else run_ls(OP_LB + 7'(sel), a, $urandom, 1'b1);
    end

    // Reset mid-store: nothing completes and round robin restarts.
    wlog_a.delete(); wlog_d.delete();
    ls_op = OP_SW; ls_addr = 32'h600; ls_data = 32'h0102_0304; ls_is_load = 1'b0;
    ls_enable = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    ls_enable = 1'b0;
    chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
    chk("midrst_mem_a", mem_a, 32'd0);
    chk("midrst_ls_valid", 32'(ls_valid), 32'd0);
    chk("midrst_ls_res", ls_res, 32'd0);
    chk("midrst_byte0_kept", 32'(ram_rd(32'h600)), 32'h04);
    rst = 1'b0;
    model_last_ls = 1'b0;
    tick();
    rr_test(1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
